// File: rtl/rx_capture_sequencer.sv
// Receive capture sequencer: releases the bit-capture reset, detects first-bit
// arrival and times link inactivity to flag a SpaceWire disconnect.
module rx_capture_sequencer #(
  parameter int unsigned DISC_CYCLES = 43,
  parameter int unsigned RESET_HOLD  = 4,
  parameter int unsigned CNT_W       = 8
) (
  input  logic       posedge_clk,
  input  logic       rx_reset,
  input  logic       rx_enable,
  input  logic       rx_din_sync,
  input  logic       rx_sin_sync,
  input  logic       err_clear,
  output logic       capture_resetn,
  output logic       capture_active,
  output logic       got_bit,
  output logic       disconnect_err,
  output logic [2:0] state
);

  typedef enum logic [2:0] {
    ST_OFF        = 3'b000,
    ST_HOLD       = 3'b001,
    ST_ARMED      = 3'b010,
    ST_ACTIVE     = 3'b011,
    ST_DISCONNECT = 3'b100
  } state_t;

  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(RESET_HOLD - 1);
  localparam logic [CNT_W-1:0] DISC_LAST = CNT_W'(DISC_CYCLES - 1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             din_q, sin_q;
  logic             activity;
  logic             got_bit_d;
  logic             err_set;

  assign activity = (rx_din_sync ^ din_q) | (rx_sin_sync ^ sin_q);

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    got_bit_d = 1'b0;
    err_set   = 1'b0;
    if (!rx_enable) begin
      state_d = ST_OFF;
      cnt_d   = '0;
    end else begin
      case (state_q)
        ST_OFF: begin
          state_d = ST_HOLD;
          cnt_d   = '0;
        end
        ST_HOLD: begin
          if (cnt_q == HOLD_LAST) begin
            state_d = ST_ARMED;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        ST_ARMED: begin
          if (activity) begin
            state_d   = ST_ACTIVE;
            got_bit_d = 1'b1;
            cnt_d     = '0;
          end
        end
        ST_ACTIVE: begin
          // Activity on the terminal edge keeps the link alive.
          if (activity) begin
            cnt_d = '0;
          end else if (cnt_q == DISC_LAST) begin
            state_d = ST_DISCONNECT;
            err_set = 1'b1;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        ST_DISCONNECT: begin
          state_d = ST_HOLD;
          cnt_d   = '0;
        end
        default: begin
          state_d = ST_OFF;
          cnt_d   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge posedge_clk or posedge rx_reset) begin
    if (rx_reset) begin
      state_q        <= ST_OFF;
      cnt_q          <= '0;
      din_q          <= 1'b0;
      sin_q          <= 1'b0;
      got_bit        <= 1'b0;
      disconnect_err <= 1'b0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      din_q          <= rx_din_sync;
      sin_q          <= rx_sin_sync;
      got_bit        <= got_bit_d;
      disconnect_err <= err_set | (disconnect_err & ~err_clear);
    end
  end

  assign capture_resetn = (state_q == ST_ARMED) || (state_q == ST_ACTIVE);
  assign capture_active = (state_q == ST_ACTIVE);
  assign state          = state_q;

endmodule
